// File: rtl/inst_fetcher.sv
// Instruction fetch front end: holds the PC, reads words from memory, presents one word to the decoder. Optional icache under ICACHE_EN.
// Latency: miss = 2 cycles + memory latency from ISSUE to inst_valid; icache hit = 1 cycle.
// Backpressure: a word is held until f_ok; rdy_in low freezes all state; a memory request is held until mem_ack.
module inst_fetcher #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          ICACHE_IDX_BIT = 6
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic [31:0] rob_clear_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    output logic        inst_valid,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_data,
    input  logic        f_ok,
    input  logic [31:0] f_next_pc
);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic        mem_req_nxt;
    logic [31:0] mem_addr_nxt;
    logic        inst_valid_nxt;
    logic [31:0] inst_addr_nxt;
    logic [31:0] inst_data_nxt;

    logic        cache_hit;
    logic [31:0] cache_dat;

`ifdef ICACHE_EN
    localparam int LINES = 1 << ICACHE_IDX_BIT;
    localparam int TAG_W = 30 - ICACHE_IDX_BIT;

    logic [LINES-1:0]          line_vld;
    logic [TAG_W-1:0]          line_tag [LINES];
    logic [31:0]               line_dat [LINES];
    logic [ICACHE_IDX_BIT-1:0] pc_idx;
    logic [TAG_W-1:0]          pc_tag;
    logic                      cache_wr;

    assign pc_idx    = pc[ICACHE_IDX_BIT+1:2];
    assign pc_tag    = pc[31:ICACHE_IDX_BIT+2];
    assign cache_hit = line_vld[pc_idx] && (line_tag[pc_idx] == pc_tag);
    assign cache_dat = line_dat[pc_idx];
    // pc equals mem_addr while in WAIT, so it indexes the returning line.
    // Data arriving alongside a clear, or while flushing, never fills.
    assign cache_wr  = rdy_in && (state == ST_WAIT) && mem_ack && !rob_clear;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            line_vld <= '0;
        end else if (cache_wr) begin
            line_vld[pc_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (cache_wr) begin
            line_tag[pc_idx] <= pc_tag;
            line_dat[pc_idx] <= mem_data;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_dat = 32'h0000_0000;
`endif

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        mem_req_nxt    = mem_req;
        mem_addr_nxt   = mem_addr;
        inst_valid_nxt = inst_valid;
        inst_addr_nxt  = inst_addr;
        inst_data_nxt  = inst_data;

        case (state)
            ST_ISSUE: begin
                if (cache_hit) begin
                    inst_data_nxt  = cache_dat;
                    inst_addr_nxt  = pc;
                    inst_valid_nxt = 1'b1;
                    state_nxt      = ST_HOLD;
                end else begin
                    mem_addr_nxt = pc;
                    mem_req_nxt  = 1'b1;
                    state_nxt    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    mem_req_nxt    = 1'b0;
                    inst_data_nxt  = mem_data;
                    inst_addr_nxt  = pc;
                    inst_valid_nxt = 1'b1;
                    state_nxt      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (f_ok) begin
                    inst_valid_nxt = 1'b0;
                    pc_nxt         = f_next_pc;
                    state_nxt      = ST_ISSUE;
                end
            end
            ST_FLUSH: begin
                if (mem_ack) begin
                    mem_req_nxt = 1'b0;
                    state_nxt   = ST_ISSUE;
                end
            end
            default: begin
                state_nxt = ST_ISSUE;
            end
        endcase

        // A clear overrides everything above; an outstanding request is drained, never withdrawn.
        if (rob_clear) begin
            pc_nxt         = rob_clear_pc;
            inst_valid_nxt = 1'b0;
            inst_addr_nxt  = inst_addr;
            inst_data_nxt  = inst_data;
            case (state)
                ST_WAIT, ST_FLUSH: begin
                    mem_addr_nxt = mem_addr;
                    mem_req_nxt  = !mem_ack;
                    state_nxt    = mem_ack ? ST_ISSUE : ST_FLUSH;
                end
                default: begin
                    mem_addr_nxt = mem_addr;
                    mem_req_nxt  = mem_req;
                    state_nxt    = ST_ISSUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= ST_ISSUE;
            pc         <= RESET_PC;
            mem_req    <= 1'b0;
            mem_addr   <= 32'h0000_0000;
            inst_valid <= 1'b0;
            inst_addr  <= 32'h0000_0000;
            inst_data  <= 32'h0000_0000;
        end else if (rdy_in) begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            mem_req    <= mem_req_nxt;
            mem_addr   <= mem_addr_nxt;
            inst_valid <= inst_valid_nxt;
            inst_addr  <= inst_addr_nxt;
            inst_data  <= inst_data_nxt;
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: directed scenarios plus randomized traffic against a transaction-level PC/memory model.
module tb_inst_fetcher;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          IDX      = 6;

    logic        clk_in;
    logic        rst_n_in;
    logic        rdy_in;
    logic        rob_clear;
    logic [31:0] rob_clear_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        inst_valid;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        f_ok;
    logic [31:0] f_next_pc;

    int          vectors     = 0;
    int          miscompares = 0;
    int          mem_lat     = 2;
    bit          rand_lat    = 1'b0;
    bit          busy        = 1'b0;
    int          cnt         = 0;
    logic        rdy_q       = 1'b1;
    logic [31:0] last_pc;

    inst_fetcher #(.RESET_PC(RESET_PC), .ICACHE_IDX_BIT(IDX)) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .rdy_in       (rdy_in),
        .rob_clear    (rob_clear),
        .rob_clear_pc (rob_clear_pc),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data),
        .inst_valid   (inst_valid),
        .inst_addr    (inst_addr),
        .inst_data    (inst_data),
        .f_ok         (f_ok),
        .f_next_pc    (f_next_pc)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a == 32'h0) ? 32'h00500093 : ((a * 32'h9E37_79B1) ^ 32'h0000_0013);
    endfunction

    always @(posedge clk_in) rdy_q <= rdy_in;

    // Memory controller model: acks a held request after a latency, frozen by rdy_in.
    always @(posedge clk_in) begin
        #1;
        if (!rst_n_in) begin
            mem_ack = 1'b0;
            busy    = 1'b0;
        end else if (rdy_q) begin
            if (mem_ack) begin
                mem_ack = 1'b0;
                busy    = 1'b0;
            end else begin
                if (mem_req && !busy) begin
                    busy = 1'b1;
                    cnt  = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
                end
                if (busy) begin
                    if (cnt == 0) begin
                        mem_ack  = 1'b1;
                        mem_data = memfn(mem_addr);
                    end else begin
                        cnt = cnt - 1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    task automatic wait_valid(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (inst_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_req(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n_in = 1'b0;
        rdy_in = 1'b1; rob_clear = 1'b0; rob_clear_pc = '0; f_ok = 1'b0; f_next_pc = '0;
        mem_ack = 1'b0; mem_data = '0;
        mem_lat = 2; rand_lat = 1'b0;
        repeat (3) tick();
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL reset_inst_valid got=%b exp=0", inst_valid); end
        vectors++; if (inst_addr !== 32'h0) begin miscompares++; $display("FAIL reset_inst_addr got=%h exp=0", inst_addr); end
        vectors++; if (inst_data !== 32'h0) begin miscompares++; $display("FAIL reset_inst_data got=%h exp=0", inst_data); end
        rst_n_in = 1'b1;
        tick();
        vectors++; if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin miscompares++; $display("FAIL first_req got=%b/%h exp=1/%h", mem_req, mem_addr, RESET_PC); end
        // Request seen, ack driven 3 edges later (mem_lat=2), word visible right after that edge.
        n = 0;
        while (inst_valid !== 1'b1 && n < 20) begin tick(); n++; end
        vectors++; if (n != 3) begin miscompares++; $display("FAIL first_latency got=%0d exp=3", n); end
        vectors++; if (inst_addr !== 32'h0 || inst_data !== 32'h00500093) begin miscompares++; $display("FAIL first_word got=%h/%h exp=0/00500093", inst_addr, inst_data); end
    endtask

    task automatic test_hold();
        bit ok;
        logic [31:0] a, d;
        rob_clear = 1'b1; rob_clear_pc = 32'h10;
        tick();
        rob_clear = 1'b0;
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL hold_clear_drop got=%b exp=0", inst_valid); end
        wait_valid(20, ok);
        vectors++; if (!ok || inst_addr !== 32'h10 || inst_data !== memfn(32'h10)) begin miscompares++; $display("FAIL hold_word got=%b/%h/%h exp=1/10/%h", ok, inst_addr, inst_data, memfn(32'h10)); end
        a = 32'h10; d = memfn(32'h10);
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++; if (inst_valid !== 1'b1 || inst_addr !== a || inst_data !== d) begin miscompares++; $display("FAIL hold_stable[%0d] got=%b/%h/%h exp=1/%h/%h", i, inst_valid, inst_addr, inst_data, a, d); end
        end
        f_ok = 1'b1; f_next_pc = 32'h40;
        tick();
        f_ok = 1'b0;
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL hold_accept_drop got=%b exp=0", inst_valid); end
        wait_req(10, ok);
        vectors++; if (!ok || mem_addr !== 32'h40) begin miscompares++; $display("FAIL hold_next_req got=%b/%h exp=1/40", ok, mem_addr); end
        wait_valid(20, ok);
        vectors++; if (!ok || inst_addr !== 32'h40) begin miscompares++; $display("FAIL hold_next_word got=%b/%h exp=1/40", ok, inst_addr); end
    endtask

    task automatic test_flush();
        bit ok;
        int n;
        mem_lat = 3;
        f_ok = 1'b1; f_next_pc = 32'h8;
        tick();
        f_ok = 1'b0;
        wait_req(10, ok);
        vectors++; if (!ok || mem_addr !== 32'h8) begin miscompares++; $display("FAIL flush_req got=%b/%h exp=1/8", ok, mem_addr); end
        rob_clear = 1'b1; rob_clear_pc = 32'h100;
        tick();
        rob_clear = 1'b0;
        n = 0;
        while (mem_req === 1'b1 && n < 20) begin
            vectors++; if (mem_addr !== 32'h8 || inst_valid !== 1'b0) begin miscompares++; $display("FAIL flush_hold got=%h/%b exp=8/0", mem_addr, inst_valid); end
            tick();
            n++;
        end
        vectors++; if (n != 3) begin miscompares++; $display("FAIL flush_drain_cycles got=%0d exp=3", n); end
        wait_req(10, ok);
        vectors++; if (!ok || mem_addr !== 32'h100) begin miscompares++; $display("FAIL flush_redirect_req got=%b/%h exp=1/100", ok, mem_addr); end
        wait_valid(20, ok);
        vectors++; if (!ok || inst_addr !== 32'h100 || inst_data !== memfn(32'h100)) begin miscompares++; $display("FAIL flush_redirect_word got=%b/%h/%h exp=1/100/%h", ok, inst_addr, inst_data, memfn(32'h100)); end
    endtask

    task automatic test_clear_fok();
        bit ok;
        rob_clear = 1'b1; rob_clear_pc = 32'h200;
        f_ok = 1'b1; f_next_pc = 32'h4;
        tick();
        rob_clear = 1'b0; f_ok = 1'b0;
        wait_req(10, ok);
        vectors++; if (!ok || mem_addr !== 32'h200) begin miscompares++; $display("FAIL clear_wins_req got=%b/%h exp=1/200", ok, mem_addr); end
        wait_valid(20, ok);
        vectors++; if (!ok || inst_addr !== 32'h200) begin miscompares++; $display("FAIL clear_wins_word got=%b/%h exp=1/200", ok, inst_addr); end
    endtask

    task automatic test_rdy();
        bit ok;
        f_ok = 1'b1; f_next_pc = 32'h20;
        tick();
        f_ok = 1'b0;
        wait_req(10, ok);
        vectors++; if (!ok || mem_addr !== 32'h20) begin miscompares++; $display("FAIL rdy_req got=%b/%h exp=1/20", ok, mem_addr); end
        rdy_in = 1'b0;
        rob_clear = 1'b1; rob_clear_pc = 32'h300; f_ok = 1'b1; f_next_pc = 32'h44;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h20 || inst_valid !== 1'b0) begin miscompares++; $display("FAIL rdy_frozen[%0d] got=%b/%h/%b exp=1/20/0", i, mem_req, mem_addr, inst_valid); end
        end
        rob_clear = 1'b0; f_ok = 1'b0;
        rdy_in = 1'b1;
        wait_valid(20, ok);
        vectors++; if (!ok || inst_addr !== 32'h20 || inst_data !== memfn(32'h20)) begin miscompares++; $display("FAIL rdy_resume got=%b/%h/%h exp=1/20/%h", ok, inst_addr, inst_data, memfn(32'h20)); end
        last_pc = 32'h20;
    endtask

`ifdef ICACHE_EN
    task automatic test_icache();
        bit ok;
        logic [31:0] conflict;
        conflict = 32'(4 << IDX);
        f_ok = 1'b1; f_next_pc = 32'h0; tick(); f_ok = 1'b0;
        wait_valid(20, ok);
        vectors++; if (!ok || inst_addr !== 32'h0) begin miscompares++; $display("FAIL ic_fill0 got=%b/%h exp=1/0", ok, inst_addr); end
        f_ok = 1'b1; f_next_pc = 32'h4; tick(); f_ok = 1'b0;
        wait_valid(20, ok);
        vectors++; if (!ok || inst_addr !== 32'h4) begin miscompares++; $display("FAIL ic_fill4 got=%b/%h exp=1/4", ok, inst_addr); end
        f_ok = 1'b1; f_next_pc = 32'h0; tick(); f_ok = 1'b0;
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL ic_gap got=%b exp=0", inst_valid); end
        tick();
        vectors++; if (inst_valid !== 1'b1 || mem_req !== 1'b0 || inst_addr !== 32'h0 || inst_data !== memfn(32'h0)) begin miscompares++; $display("FAIL ic_hit got=%b/%b/%h/%h exp=1/0/0/%h", inst_valid, mem_req, inst_addr, inst_data, memfn(32'h0)); end
        f_ok = 1'b1; f_next_pc = conflict; tick(); f_ok = 1'b0;
        tick();
        vectors++; if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== conflict) begin miscompares++; $display("FAIL ic_conflict got=%b/%b/%h exp=0/1/%h", inst_valid, mem_req, mem_addr, conflict); end
        wait_valid(20, ok);
        vectors++; if (!ok || inst_addr !== conflict || inst_data !== memfn(conflict)) begin miscompares++; $display("FAIL ic_conflict_word got=%b/%h/%h exp=1/%h/%h", ok, inst_addr, inst_data, conflict, memfn(conflict)); end
        last_pc = conflict;
    endtask
`endif

    task automatic test_random();
        logic [31:0] exp_pc;
        logic        p_req, p_valid, p_ack, p_rdy;
        logic [31:0] p_addr, p_iaddr, p_idata;
        int          presented, idle;
        rand_lat = 1'b1;
        exp_pc = last_pc;
        presented = 0;
        idle = 0;
        p_req = mem_req; p_addr = mem_addr; p_valid = inst_valid; p_iaddr = inst_addr; p_idata = inst_data;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rdy_in       = ($urandom_range(0, 7) != 0);
            rob_clear    = ($urandom_range(0, 11) == 0);
            rob_clear_pc = 32'($urandom_range(0, 63)) << 2;
            f_ok         = inst_valid ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
            f_next_pc    = 32'($urandom_range(0, 63)) << 2;
            if (rdy_in) begin
                if (rob_clear) exp_pc = rob_clear_pc;
                else if (f_ok && inst_valid) exp_pc = f_next_pc;
            end
            p_ack = mem_ack;
            p_rdy = rdy_in;
            tick();
            if (!p_rdy) begin
                vectors++;
                if (mem_req !== p_req || mem_addr !== p_addr || inst_valid !== p_valid || inst_addr !== p_iaddr || inst_data !== p_idata) begin
                    miscompares++; $display("FAIL rnd_frozen cyc=%0d got=%b/%h/%b/%h exp=%b/%h/%b/%h", cyc, mem_req, mem_addr, inst_valid, inst_addr, p_req, p_addr, p_valid, p_iaddr);
                end
            end else begin
                if (inst_valid && !p_valid) begin
                    presented++; idle = 0;
                    vectors++;
                    if (inst_addr !== exp_pc || inst_data !== memfn(exp_pc)) begin miscompares++; $display("FAIL rnd_word cyc=%0d got=%h/%h exp=%h/%h", cyc, inst_addr, inst_data, exp_pc, memfn(exp_pc)); end
                end
                if (inst_valid && p_valid) begin
                    vectors++;
                    if (inst_addr !== p_iaddr || inst_data !== p_idata) begin miscompares++; $display("FAIL rnd_hold_stable cyc=%0d got=%h/%h exp=%h/%h", cyc, inst_addr, inst_data, p_iaddr, p_idata); end
                end
                if (mem_req && !p_req) begin
                    vectors++;
                    if (mem_addr !== exp_pc) begin miscompares++; $display("FAIL rnd_req_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, exp_pc); end
                end
                if (mem_req && p_req) begin
                    vectors++;
                    if (mem_addr !== p_addr) begin miscompares++; $display("FAIL rnd_addr_stable cyc=%0d got=%h exp=%h", cyc, mem_addr, p_addr); end
                end
                if (p_req) begin
                    vectors++;
                    if (mem_req !== !p_ack) begin miscompares++; $display("FAIL rnd_req_release cyc=%0d got=%b exp=%b", cyc, mem_req, !p_ack); end
                end
            end
            idle++;
            if (idle > 300) begin
                miscompares++; $display("FAIL rnd_stall cyc=%0d got=no word for %0d cycles exp=progress", cyc, idle);
                break;
            end
            p_req = mem_req; p_addr = mem_addr; p_valid = inst_valid; p_iaddr = inst_addr; p_idata = inst_data;
        end
        rdy_in = 1'b1; rob_clear = 1'b0; f_ok = 1'b0;
        vectors++;
        if (presented < 50) begin miscompares++; $display("FAIL rnd_throughput got=%0d words exp>=50", presented); end
    endtask

    initial begin
        rst_n_in = 1'b0;
        last_pc = RESET_PC;
        test_reset();
        test_hold();
        test_flush();
        test_clear_fok();
        test_rdy();
`ifdef ICACHE_EN
        test_icache();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=still running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
